pwm_dac: RTL and testbench
==========================

// Module: pwm_dac
// PURPOSE
//   Turns the mixer's 8-bit output into a single-bit PWM stream for the external RC
//   low-pass filter on the audio pin. Sits downstream of the mixer and directly drives the pad.
//   Latches one sample per PWM period so duty changes are glitch-free.
//   Optional clock prescaler trades PWM carrier frequency for pad/filter friendliness.
//   Graceful stop: disabling finishes the running period before idling low.
// PARAMETERS
//   WIDTH       8   sample / PWM counter width; period = 2**WIDTH steps
//   PRESCALE_W  4   width of prescale divider input
// PORTS
//   clk          in   1           system clock
//   rst          in   1           reset, asynchronous, active-high
//   enable       in   1           run request; sampled every clk
//   prescale     in   PRESCALE_W  step = every (prescale+1) clks; latched per period
//   sample       in   WIDTH       duty value (mixer output); latched per period
//   pwm_out      out  1           PWM output to pad
//   period_tick  out  1           1-clk pulse on the last clk of every period
//   active       out  1           high while state != IDLE
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, cnt=0, pre=0, duty_q=0, presc_q=0;
//     pwm_out=0, period_tick=0, active=0 immediately, regardless of clk.
//   Registers: cnt[WIDTH], pre[PRESCALE_W], duty_q[WIDTH], presc_q[PRESCALE_W].
//   step = (pre == presc_q); pre increments each clk in RUN/DRAIN, clears to 0 on step.
//   cnt increments on step only, wraps 2**WIDTH-1 -> 0. wrap = step && cnt==2**WIDTH-1.
//   States:
//     IDLE : cnt=0, pre=0. enable=1 -> RUN; same edge duty_q<=sample, presc_q<=prescale.
//     RUN  : on wrap: if enable -> stay RUN, duty_q<=sample, presc_q<=prescale;
//            else -> IDLE. enable=0 before wrap -> DRAIN (no latch).
//     DRAIN: period completes with current duty_q; enable=1 again -> RUN (no latch).
//            On wrap -> IDLE.
//   Both latch points fall only on IDLE->RUN or on wrap in RUN; sample/prescale changes
//     mid-period have no effect until next period.
//   pwm_out = (state != IDLE) && (cnt < duty_q); decoded from flops only, no comb path
//     from any input. duty 0 -> constant 0; duty 2**WIDTH-1 -> high 255 of 256 steps.
//   period_tick = (state != IDLE) && wrap; fires also on the final DRAIN period.
//   active = (state != IDLE).
//   First RUN clk after IDLE: cnt=0, pwm_out=(duty_q>0); latency enable->pwm = 1 clk.
//   Period length = 2**WIDTH * (presc_q+1) clks, exact, back-to-back with no gap in RUN.
//   Simultaneous wrap and enable fall: treated as RUN wrap with enable=0 -> IDLE.
//   Reset mid-period: output low at once; restart only via IDLE->RUN after rst release.
// TESTING
//   prescale=0, sample=0x40, enable=1 -> pwm high 64 clks, low 192, period_tick every 256.
//   sample=0x00 / 0xFF -> pwm never high / high 255 clks, low 1, per period.
//   sample 0x40->0xC0 at cnt=100 -> current period keeps 64 high; next period 192 high.
//   prescale=3, sample=0x80 -> period 1024 clks, 512 high; prescale change mid-period deferred.
//   enable 1->0 at cnt=10 -> period runs to cnt=255, tick pulses, then active=0, pwm=0.
//   rst pulse at cnt=50 with pwm high -> pwm_out, active, period_tick 0 without clk edge.

Source files
------------

// File: rtl/pwm_dac.sv
// PWM DAC: turns an 8-bit mixer sample into a single-bit PWM stream for an external RC filter.
// One sample and one prescale value are latched per PWM period; disabling lets the running period finish.
module pwm_dac #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      sample,
    output logic                  pwm_out,
    output logic                  period_tick,
    output logic                  active
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [PRESCALE_W-1:0]   pre_q, pre_d;
    logic [WIDTH-1:0]        duty_q, duty_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;

    logic step_c;
    logic wrap_c;

    assign step_c = (pre_q == presc_q);
    assign wrap_c = step_c && (cnt_q == CNT_MAX);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            duty_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            duty_q  <= duty_d;
            presc_q <= presc_d;
        end
    end

    // Next-state, counter advance and per-period latching
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        duty_d  = duty_q;
        presc_d = presc_q;

        if (state_q != IDLE) begin
            pre_d = step_c ? '0 : pre_q + PRESCALE_W'(1);
            cnt_d = step_c ? cnt_q + WIDTH'(1) : cnt_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pre_d = '0;
                if (enable) begin
                    state_d = RUN;
                    duty_d  = sample;
                    presc_d = prescale;
                end
            end
            RUN: begin
                if (wrap_c) begin
                    if (enable) begin
                        duty_d  = sample;
                        presc_d = prescale;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A draining period always ends in IDLE; re-enable only cancels the stop mid-period
                if (wrap_c) begin
                    state_d = IDLE;
                end else if (enable) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only flops, so async reset clears them without a clock edge
    assign active      = (state_q != IDLE);
    assign pwm_out     = active && (cnt_q < duty_q);
    assign period_tick = active && wrap_c;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: directed period measurements plus randomized stimulus
// compared every cycle against a period/position model of the PWM stream.
module tb_pwm_dac;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PRESCALE_W = 4;
    localparam int          STEPS      = 1 << WIDTH;

    logic                  clk;
    logic                  rst;
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      sample;
    logic                  pwm_out;
    logic                  period_tick;
    logic                  active;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_dac #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .prescale   (prescale),
        .sample     (sample),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: position k (clks) within a period of STEPS*(p+1) clks, duty d, stop request pending
    bit m_act;
    bit m_stop;
    int m_k;
    int m_d;
    int m_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_stop = 0; m_k = 0; m_d = 0; m_p = 0;
        end else if (!m_act) begin
            if (enable) begin
                m_act = 1; m_stop = 0; m_k = 0;
                m_d = int'(sample); m_p = int'(prescale);
            end
        end else if (m_k == STEPS * (m_p + 1) - 1) begin
            if (!m_stop && enable) begin
                m_k = 0; m_d = int'(sample); m_p = int'(prescale);
            end else begin
                m_act = 0; m_k = 0;
            end
        end else begin
            m_k++;
            m_stop = !enable;
        end
    end

    always @(negedge clk) begin
        int e_pwm;
        int e_tick;
        e_pwm  = (m_act && (m_k / (m_p + 1)) < m_d) ? 1 : 0;
        e_tick = (m_act && m_k == STEPS * (m_p + 1) - 1) ? 1 : 0;
        check("model_pwm_out", int'(pwm_out), e_pwm);
        check("model_period_tick", int'(period_tick), e_tick);
        check("model_active", int'(active), m_act ? 1 : 0);
    end

    // Counts clks and high clks up to and including the next period_tick
    task automatic count_period(input int chg_at, input int new_s, input int new_en, input int new_p,
                                output int len, output int hi);
        bit seen;
        len = 0; hi = 0; seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            len++;
            if (pwm_out) hi++;
            if (len == chg_at) begin
                sample   = WIDTH'(new_s);
                enable   = new_en[0];
                prescale = PRESCALE_W'(new_p);
            end
            if (period_tick) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("period_timeout", 0, 1);
    endtask

    initial begin
        int len;
        int hi;
        rst = 1'b1; enable = 1'b0; sample = '0; prescale = '0;
        #1;
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_tick", int'(period_tick), 0);
        check("reset_active", int'(active), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_active", int'(active), 0);

        enable = 1'b1; sample = 8'h40; prescale = '0;
        count_period(-1, 0, 1, 0, len, hi);
        check("p0_s40_len", len, 256);
        check("p0_s40_high", hi, 64);

        sample = 8'h00;
        count_period(-1, 0, 1, 0, len, hi);
        check("s00_len", len, 256);
        check("s00_high", hi, 0);

        sample = 8'hFF;
        count_period(-1, 0, 1, 0, len, hi);
        check("sFF_len", len, 256);
        check("sFF_high", hi, 255);

        sample = 8'h40;
        count_period(101, 8'hC0, 1, 0, len, hi);
        check("midchange_cur_high", hi, 64);
        count_period(-1, 0, 1, 0, len, hi);
        check("midchange_next_len", len, 256);
        check("midchange_next_high", hi, 192);

        sample = 8'h80; prescale = 4'd3;
        count_period(300, 8'h80, 1, 0, len, hi);
        check("p3_len", len, 1024);
        check("p3_high", hi, 512);
        count_period(-1, 0, 1, 0, len, hi);
        check("p3_deferred_len", len, 256);
        check("p3_deferred_high", hi, 128);

        sample = 8'h40;
        count_period(11, 8'h40, 0, 0, len, hi);
        check("drain_len", len, 256);
        check("drain_high", hi, 64);
        @(negedge clk);
        check("drain_done_active", int'(active), 0);
        check("drain_done_pwm", int'(pwm_out), 0);

        enable = 1'b1; sample = 8'h80;
        repeat (51) @(negedge clk);
        check("pre_rst_pwm", int'(pwm_out), 1);
        check("pre_rst_active", int'(active), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm_out), 0);
        check("async_rst_active", int'(active), 0);
        check("async_rst_tick", int'(period_tick), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) sample = WIDTH'($urandom);
            if ($urandom_range(0, 63) == 0) prescale = PRESCALE_W'($urandom_range(0, 3));
            if ($urandom_range(0, 4999) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        enable = 1'b0;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
